// File: rtl/qc12864_bus_writer.sv
// Write-only parallel bus driver for a QC12864 (ST7920-style) LCD.
// Each accepted word runs SETUP, E_HIGH, HOLD and then an execution GAP.
module qc12864_bus_writer #(
   parameter int SETUP_CYC    = 4,
   parameter int E_HIGH_CYC   = 12,
   parameter int HOLD_CYC     = 4,
   parameter int GAP_CYC      = 4000,
   parameter int LONG_GAP_CYC = 90000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd_word,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_e,
   output logic [7:0]  lcd_db,
   output logic [15:0] words_sent
);

   function automatic int clamp1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int S_N  = clamp1(SETUP_CYC);
   localparam int E_N  = clamp1(E_HIGH_CYC);
   localparam int H_N  = clamp1(HOLD_CYC);
   localparam int G_N  = clamp1(GAP_CYC);
   localparam int LG_N = clamp1(LONG_GAP_CYC);

   localparam int MAXN = max2(max2(max2(S_N, E_N), max2(H_N, G_N)), LG_N);
   localparam int CW   = ($clog2(MAXN) > 17) ? $clog2(MAXN) : 17;

   localparam logic [CW-1:0] S_LD  = CW'(S_N - 1);
   localparam logic [CW-1:0] E_LD  = CW'(E_N - 1);
   localparam logic [CW-1:0] H_LD  = CW'(H_N - 1);
   localparam logic [CW-1:0] G_LD  = CW'(G_N - 1);
   localparam logic [CW-1:0] LG_LD = CW'(LG_N - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] E_HIGH = 3'd2;
   localparam logic [2:0] HOLD   = 3'd3;
   localparam logic [2:0] GAP    = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          long_gap;
   logic          is_clear;
   logic          cnt_done;
   logic          unused_bits;

   assign unused_bits = ^cmd_word[15:9];
   assign lcd_rw      = 1'b0;
   assign cmd_ready   = (state == IDLE) && !rst;
   assign cnt_done    = (cnt == '0);

   // clear / home / entry-home commands need the long execution wait
   assign is_clear = !cmd_word[8] && (cmd_word[7:2] == 6'd0)
                     && (cmd_word[1:0] != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         long_gap   <= 1'b0;
         lcd_e      <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_db     <= 8'h00;
         words_sent <= 16'h0000;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  lcd_rs   <= cmd_word[8];
                  lcd_db   <= cmd_word[7:0];
                  long_gap <= is_clear;
                  cnt      <= S_LD;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_done) begin
                  cnt   <= E_LD;
                  lcd_e <= 1'b1;
                  state <= E_HIGH;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            E_HIGH: begin
               if (cnt_done) begin
                  cnt   <= H_LD;
                  lcd_e <= 1'b0;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               if (cnt_done) begin
                  cnt        <= long_gap ? LG_LD : G_LD;
                  words_sent <= words_sent + 16'd1;
                  state      <= GAP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            GAP: begin
               if (cnt_done) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               lcd_e <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qc12864_bus_writer.sv
// Directed and random-stream bench for qc12864_bus_writer.
// Timing uses small overrides so each word takes only a few cycles.
module tb_qc12864_bus_writer;

   localparam int S  = 2;
   localparam int E  = 3;
   localparam int H  = 2;
   localparam int G  = 5;
   localparam int LG = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cmd_word = 16'h0000;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_e;
   logic [7:0]  lcd_db;
   logic [15:0] words_sent;

   int n_vec = 0;
   int n_err = 0;

   int pulses = 0;
   int accepts = 0;
   int viol = 0;
   int rw_viol = 0;
   logic       m_rs = 1'b0;
   logic [7:0] m_db = 8'h00;

   qc12864_bus_writer #(
      .SETUP_CYC(S), .E_HIGH_CYC(E), .HOLD_CYC(H),
      .GAP_CYC(G), .LONG_GAP_CYC(LG)
   ) dut (
      .clk(clk), .rst(rst), .cmd_word(cmd_word),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_db(lcd_db), .words_sent(words_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference latch of the accepted word, independent of DUT state
   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) begin
         accepts <= accepts + 1;
         m_rs    <= cmd_word[8];
         m_db    <= cmd_word[7:0];
      end
   end

   always @(posedge lcd_e) pulses++;

   always @(negedge clk) begin
      if (!rst && !cmd_ready && (lcd_rs !== m_rs || lcd_db !== m_db))
         viol++;
      if (lcd_rw !== 1'b0)
         rw_viol++;
   end

   // Called at a negedge with the DUT idle; returns at the negedge where
   // cmd_ready is seen high again.
   task automatic xfer(input logic [15:0] w, input int exp_lat,
                       input bit keep_valid, input logic [15:0] exp_ws);
      int e_first;
      int e_cnt;
      int lat;
      int bad;
      e_first = -1;
      e_cnt   = 0;
      lat     = -1;
      bad     = 0;
      check("ready_before", 32'(cmd_ready), 32'd1);
      cmd_word  = w;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!keep_valid) cmd_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 0) check("accepted", 32'(cmd_ready), 32'd0);
         if (cmd_ready) begin
            lat = i;
            break;
         end
         if (lcd_e) begin
            if (e_first < 0) e_first = i;
            e_cnt++;
         end
         if (lcd_rs !== w[8] || lcd_db !== w[7:0]) bad++;
      end
      check("ready_latency", 32'(lat), 32'(exp_lat));
      check("e_start", 32'(e_first), 32'(S));
      check("e_width", 32'(e_cnt), 32'(E));
      check("rs_db_stable", 32'(bad), 32'd0);
      check("rs_db_idle", {23'd0, lcd_rs, lcd_db}, {23'd0, w[8:0]});
      check("words_sent", 32'(words_sent), 32'(exp_ws));
   endtask

   initial begin
      int cyc;
      logic [15:0] ws0;
      logic [15:0] w;

      #2;
      check("ready_in_rst", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_e", 32'(lcd_e), 32'd0);
      check("rst_rs", 32'(lcd_rs), 32'd0);
      check("rst_db", 32'(lcd_db), 32'd0);
      check("rst_rw", 32'(lcd_rw), 32'd0);
      check("rst_ws", 32'(words_sent), 32'd0);
      @(negedge clk);

      xfer(16'h0034, S + E + H + G, 1'b0, 16'd1);
      xfer(16'h0100, S + E + H + G, 1'b1, 16'd2);
      xfer(16'h01AB, S + E + H + G, 1'b0, 16'd3);
      xfer(16'h0001, S + E + H + LG, 1'b0, 16'd4);
      xfer(16'h0101, S + E + H + G, 1'b0, 16'd5);
      xfer(16'h0003, S + E + H + LG, 1'b0, 16'd6);
      xfer(16'hFE02, S + E + H + LG, 1'b0, 16'd7);
      xfer(16'h0004, S + E + H + G, 1'b0, 16'd8);

      // reset while E is high
      cmd_word  = 16'h0036;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < S + 1; i++) @(negedge clk);
      check("e_before_rst", 32'(lcd_e), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_e", 32'(lcd_e), 32'd0);
      check("mid_rst_db", 32'(lcd_db), 32'd0);
      check("mid_rst_rs", 32'(lcd_rs), 32'd0);
      check("mid_rst_ws", 32'(words_sent), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xfer(16'h0036, S + E + H + G, 1'b0, 16'd1);

      // wrap of the word counter
      force dut.words_sent = 16'hFFFF;
      #1;
      release dut.words_sent;
      @(negedge clk);
      xfer(16'h0155, S + E + H + G, 1'b0, 16'h0000);

      // random stream
      ws0     = words_sent;
      pulses  = 0;
      @(posedge clk);
      accepts <= 0;
      viol    = 0;
      rw_viol = 0;
      @(negedge clk);
      cyc = 0;
      while (accepts < 1000 && cyc < 60000) begin
         w = 16'($urandom);
         if ($urandom_range(0, 7) == 0)
            w = {7'd0, 1'b0, 6'd0, 2'($urandom_range(1, 3))};
         cmd_word  = w;
         cmd_valid = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         cyc++;
      end
      cmd_valid = 1'b0;
      check("stream_done", 32'(accepts), 32'd1000);
      cyc = 0;
      while (!cmd_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("stream_idle", 32'(cmd_ready), 32'd1);
      check("pulses_vs_accepts", 32'(pulses), 32'(accepts));
      check("rs_db_changes", 32'(viol), 32'd0);
      check("rw_nonzero", 32'(rw_viol), 32'd0);
      check("stream_ws", 32'(words_sent), 32'(16'(ws0 + 16'(accepts))));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qc12864_bus_writer.md
QC12864_BUS_WRITER -- requirements
Module: qc12864_bus_writer

Interface
REQ-001 Parameter SETUP_CYC, 4, clocks with RS/DB stable before E rises.
REQ-002 Parameter E_HIGH_CYC, 12, clocks E is held high.
REQ-003 Parameter HOLD_CYC, 4, clocks RS/DB stay stable after E falls.
REQ-004 Parameter GAP_CYC, 4000, LCD execution wait after a normal word (80 us at 50 MHz).
REQ-005 Parameter LONG_GAP_CYC, 90000, execution wait after clear/home commands (1.8 ms at 50 MHz).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cmd_word  input  16  bit 8 = RS (0 command, 1 data), bits 7:0 = DB byte, bits 15:9 ignored.
REQ-009 cmd_valid  input  1  upstream word present.
REQ-010 cmd_ready  output  1  block can accept a word this cycle.
REQ-011 lcd_rs  output  1  LCD register select.
REQ-012 lcd_rw  output  1  LCD read/write; constant 0 (write only).
REQ-013 lcd_e  output  1  LCD enable strobe.
REQ-014 lcd_db  output  8  LCD data bus.
REQ-015 words_sent  output  16  count of completed words, wraps 0xFFFF -> 0x0000.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, E_HIGH, HOLD, GAP, using one down-counter of at least 17 bits.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a word is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-018 On accept, the block SHALL register lcd_rs=cmd_word[8] and lcd_db=cmd_word[7:0] and enter SETUP on the same edge; cmd_word is not sampled again until the next accept.
REQ-019 SETUP SHALL last SETUP_CYC cycles with lcd_e=0, then E_HIGH lasts E_HIGH_CYC cycles with lcd_e=1, then HOLD lasts HOLD_CYC cycles with lcd_e=0.
REQ-020 GAP SHALL last LONG_GAP_CYC cycles when the accepted word has RS=0 and DB equal to 0x01 or 0x02 or 0x03; otherwise it SHALL last GAP_CYC cycles.
REQ-021 The GAP length SHALL be selected at accept time from the latched word.
REQ-022 lcd_rs and lcd_db SHALL hold the latched values from accept through the end of GAP; in IDLE they keep the last word's values.
REQ-023 words_sent SHALL increment by 1 on the edge that leaves HOLD.
REQ-024 On the final GAP cycle the block SHALL return to IDLE, so cmd_ready=1 exactly SETUP_CYC+E_HIGH_CYC+HOLD_CYC+GAP_CYC cycles after the accept edge.
REQ-025 Back-to-back words with cmd_valid held high SHALL be accepted on the first IDLE cycle, so the IDLE dwell is one cycle.
REQ-026 Any timing parameter set to 0 SHALL behave as 1.
REQ-027 lcd_e SHALL be driven from a register (glitch-free) and SHALL never be 1 outside E_HIGH.
REQ-028 cmd_valid dropping while the block is busy SHALL have no effect on an accepted word.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, counter=0, lcd_e=0, lcd_rs=0, lcd_db=0x00, lcd_rw=0, words_sent=0; cmd_ready is 1 while rst=0 and state=IDLE.
REQ-030 Reset asserted mid-transfer SHALL drop lcd_e immediately and discard the word, without incrementing words_sent.
REQ-031 The first accept after reset release SHALL occur no earlier than the first rising edge with rst=0.

Verification (bench overrides: SETUP=2, E_HIGH=3, HOLD=2, GAP=5, LONG_GAP=20)
REQ-032 Send 0x0034 -> rs=0, db=0x34, e=0 for 2 cycles, then e=1 for 3, then e=0 for 2; words_sent=1; cmd_ready returns 12 cycles after accept.
REQ-033 Send 0x0100 then 0x01AB with cmd_valid held -> both transfer with rs=1; second accept 1 cycle after ready rises; db=0x00 then 0xAB; words_sent=2.
REQ-034 Send 0x0001 -> GAP of 20 cycles, ready after 27 cycles; send 0x0101 -> GAP of 5 cycles (data, not clear).
REQ-035 Assert rst during E_HIGH of 0x0036 -> lcd_e=0 the same time step; outputs at reset values; words_sent=0; next word transfers normally.
REQ-036 Preload words_sent=0xFFFF by 65535 transfers (or force) and send one more word -> words_sent=0x0000.
REQ-037 Random cmd_valid/cmd_word stream over 1000 words -> lcd_e pulse count equals the number of accepts; RS/DB never change while e=1 or during HOLD; lcd_rw is always 0.
